spart_fifo: RTL
===============

// Module: spart_fifo
// PURPOSE
//  Parametrised successor of the SPART serial port: full-duplex UART with programmable 16x baud divisor,
//  RX/TX FIFOs, configurable frame length and sticky error flags. Sits between the processor's
//  8-bit tri-state I/O bus (iocs/iorw/ioaddr/databus) and the board serial pins (txd/rxd).
// PARAMETERS
//  FRAME_W      8    data bits per frame, 5..8; unused high bus bits ignored on TX, read 0 on RX
//  FIFO_DEPTH   4    entries per FIFO (RX and TX), power of 2, >=2
//  DEFAULT_DIV  651  divisor loaded at reset (100 MHz clk, 9600 baud x16)
// PORTS
//  clk      in     1  system clock
//  rst      in     1  asynchronous, active-low reset
//  iocs     in     1  chip select; one access per cycle while high
//  iorw     in     1  1 = read, 0 = write
//  ioaddr   in     2  00 data, 01 status, 10 divisor low, 11 divisor high
//  databus  inout  8  driven only when iocs & iorw, else 8'hzz
//  rda      out    1  RX FIFO not empty
//  tbr      out    1  TX FIFO not full
//  txd      out    1  serial out, idle high
//  rxd      in     1  serial in, async; 2-flop synchroniser, reset to 1
// BEHAVIOUR
//  Reset (rst=0, immediate): txd=1, rda=0, tbr=1, FIFOs empty, FSMs IDLE, flags 0, div=DEFAULT_DIV.
//  Bus: write 00 = push TX; read 00 = pop RX (combinational data, pop at clk edge);
//   read 01 = {2'b0, perr, ferr, rx_ovf, tx_empty, tbr, rda}, clears perr/ferr/rx_ovf that edge;
//   write 10/11 = div[7:0]/div[15:8], counter reloads on write; read 10/11 returns div bytes.
//  Push to full TX FIFO dropped, no state change. Pop of empty RX FIFO returns 8'h00, no change.
//  FIFO same-cycle push+pop: count unchanged; legal when full (pop frees slot) and when empty
//   (RX: push then pop order not required; empty+push+pop -> push only, pop returns 00).
//  Baud: down-counter reloads div-1, tick 1 clk wide at 0; div=0 -> no ticks (TX/RX frozen).
//  TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE; each bit = 16 ticks, LSB first.
//   IDLE with TX FIFO non-empty pops on next tick, txd=0 that cycle. After STOP, back-to-back
//   frames with no idle gap. tx_empty = FIFO empty & FSM IDLE.
//  RX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE; falling rxd in IDLE restarts tick count;
//   START samples at tick 8: rxd=1 -> false start, back to IDLE. Data sampled every 16 ticks.
//   STOP sample: rxd=0 -> ferr=1, frame discarded; else push; RX FIFO full -> drop, rx_ovf=1.
//   rda rises the cycle after the stop-bit sample. Returns to IDLE at mid-stop (resync ready).
//  Error flag set and status-read clear in same cycle: set wins.
//  Divisor write mid-frame: legal, frame continues at new rate; no corruption guarantee.
// CONFIGURATION
//  SPART_PARITY_EN defined: even parity bit after data (TX generated, RX checked);
//   mismatch -> frame discarded, perr=1. Undefined: no parity bit in frame, status bit5 reads 0.
// TESTING
//  Reset: rst=0 mid TX frame -> txd=1 same cycle; after release status read = 8'h06, databus z.
//  Loopback txd->rxd, div=2: write 8'hA5 -> rda=1 after 10 bit times (11 w/ parity); read 00 = 8'hA5.
//  TX FIFO fill: 5 writes 8'h01..05 with line busy, DEPTH=4 -> tbr=0 after 4th, 05 dropped; 01..04 sent.
//  RX overflow: inject 5 frames with no reads -> rda=1, status bit3=1; reads 01..04, then 00; flag cleared.
//  Framing/false start: rxd low 4 ticks -> no frame; frame with stop=0 -> ferr=1, rda stays 0.
//  Parity (SPART_PARITY_EN): inject 8'h03 with parity 1 -> perr=1, discarded; parity 0 -> 8'h03 read.

Source files
------------

// File: rtl/spart_fifo.sv
// SPART serial port with RX/TX FIFOs: full-duplex UART, 16x baud divisor, sticky error flags.
// Optional even-parity bit in every frame when SPART_PARITY_EN is defined.
module spart_fifo #(
    parameter int FRAME_W     = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 651
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [15:0]   DIV_RST  = 16'(DEFAULT_DIV);
    localparam logic [2:0]    LAST_BIT = 3'(FRAME_W - 1);
`ifdef SPART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    logic [15:0]        r_div;
    logic [15:0]        r_baud_cnt;
    logic [FRAME_W-1:0] r_tx_mem [FIFO_DEPTH];
    logic [FRAME_W-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [CW-1:0]      r_tx_cnt, r_rx_cnt;
    state_t             r_tx_st, r_rx_st;
    logic [3:0]         r_tx_tcnt, r_rx_tcnt;
    logic [2:0]         r_tx_bit, r_rx_bit;
    logic [FRAME_W-1:0] r_tx_sh, r_rx_sh;
    logic               r_tx_par, r_rx_par;
    logic               r_txd, r_rda, r_tbr;
    logic               r_rxd_s1, r_rxd_s2, r_rxd_prev;
    logic               r_perr, r_ferr, r_ovf;

    logic               w_wr, w_rd, w_tick, w_tx_empty, w_rxd, w_fall;
    logic               w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_push_req;
    logic               w_stop_smp, w_par_bad, w_ferr_set, w_perr_set, w_ovf_set;
    logic               w_div_lo_wr, w_div_hi_wr, w_stat_rd;
    logic [15:0]        w_div_next;
    logic [CW-1:0]      w_tx_cnt_next, w_rx_cnt_next;
    logic [7:0]         w_rd_data;

    assign w_wr        = iocs & ~iorw;
    assign w_rd        = iocs & iorw;
    assign w_div_lo_wr = w_wr & (ioaddr == 2'b10);
    assign w_div_hi_wr = w_wr & (ioaddr == 2'b11);
    assign w_stat_rd   = w_rd & (ioaddr == 2'b01);
    assign w_tick      = (r_baud_cnt == 16'd0) && (r_div != 16'd0);
    assign w_rxd       = r_rxd_s2;
    assign w_fall      = r_rxd_prev & ~r_rxd_s2;
    assign w_tx_empty  = (r_tx_cnt == CNT_ZERO) && (r_tx_st == ST_IDLE);

    // TX pops when idle or at the end of a stop bit, so consecutive frames have no gap
    assign w_tx_pop  = w_tick && (r_tx_cnt != CNT_ZERO) &&
                       ((r_tx_st == ST_IDLE) || ((r_tx_st == ST_STOP) && (r_tx_tcnt == 4'd15)));
    assign w_tx_push = w_wr && (ioaddr == 2'b00) && ((r_tx_cnt != CNT_FULL) || w_tx_pop);

    assign w_stop_smp    = w_tick && (r_rx_st == ST_STOP) && (r_rx_tcnt == 4'd15);
    assign w_par_bad     = PAR_EN && (r_rx_par != (^r_rx_sh));
    assign w_ferr_set    = w_stop_smp && !w_rxd;
    assign w_perr_set    = w_stop_smp && w_rxd && w_par_bad;
    assign w_rx_push_req = w_stop_smp && w_rxd && !w_par_bad;
    assign w_rx_pop      = w_rd && (ioaddr == 2'b00) && (r_rx_cnt != CNT_ZERO);
    assign w_rx_push     = w_rx_push_req && ((r_rx_cnt != CNT_FULL) || w_rx_pop);
    assign w_ovf_set     = w_rx_push_req && !w_rx_push;

    assign databus = w_rd ? w_rd_data : 8'hzz;
    assign txd     = r_txd;
    assign rda     = r_rda;
    assign tbr     = r_tbr;

    // Next divisor value from bus byte writes
    always_comb begin
        w_div_next = r_div;
        if (w_div_lo_wr) begin
            w_div_next = {r_div[15:8], databus};
        end else if (w_div_hi_wr) begin
            w_div_next = {databus, r_div[7:0]};
        end else begin
            w_div_next = r_div;
        end
    end

    // Next FIFO occupancies
    always_comb begin
        w_tx_cnt_next = r_tx_cnt;
        w_rx_cnt_next = r_rx_cnt;
        if (w_tx_push && !w_tx_pop) begin
            w_tx_cnt_next = r_tx_cnt + CNT_ONE;
        end else if (!w_tx_push && w_tx_pop) begin
            w_tx_cnt_next = r_tx_cnt - CNT_ONE;
        end else begin
            w_tx_cnt_next = r_tx_cnt;
        end
        if (w_rx_push && !w_rx_pop) begin
            w_rx_cnt_next = r_rx_cnt + CNT_ONE;
        end else if (!w_rx_push && w_rx_pop) begin
            w_rx_cnt_next = r_rx_cnt - CNT_ONE;
        end else begin
            w_rx_cnt_next = r_rx_cnt;
        end
    end

    // Bus read multiplexer; an empty RX FIFO reads as zero
    always_comb begin
        w_rd_data = 8'h00;
        case (ioaddr)
            2'b00: begin
                if (r_rx_cnt != CNT_ZERO) begin
                    w_rd_data[FRAME_W-1:0] = r_rx_mem[r_rx_rp];
                end else begin
                    w_rd_data = 8'h00;
                end
            end
            2'b01:   w_rd_data = {2'b00, r_perr, r_ferr, r_ovf, w_tx_empty, r_tbr, r_rda};
            2'b10:   w_rd_data = r_div[7:0];
            2'b11:   w_rd_data = r_div[15:8];
            default: w_rd_data = 8'h00;
        endcase
    end

    // Divisor register and 16x baud tick down-counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= DIV_RST;
            r_baud_cnt <= DIV_RST - 16'd1;
        end else begin
            r_div <= w_div_next;
            if (w_div_lo_wr || w_div_hi_wr) begin
                r_baud_cnt <= w_div_next - 16'd1;
            end else if (w_tick) begin
                r_baud_cnt <= r_div - 16'd1;
            end else if (r_div != 16'd0) begin
                r_baud_cnt <= r_baud_cnt - 16'd1;
            end
        end
    end

    // FIFO storage, pointers, counts and the registered rda/tbr outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_tx_mem[i] <= '0;
                r_rx_mem[i] <= '0;
            end
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_rda    <= 1'b0;
            r_tbr    <= 1'b1;
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wp] <= databus[FRAME_W-1:0];
                r_tx_wp           <= r_tx_wp + PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rp <= r_tx_rp + PTR_ONE;
            end
            if (w_rx_push) begin
                r_rx_mem[r_rx_wp] <= r_rx_sh;
                r_rx_wp           <= r_rx_wp + PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + PTR_ONE;
            end
            r_tx_cnt <= w_tx_cnt_next;
            r_rx_cnt <= w_rx_cnt_next;
            r_rda    <= (w_rx_cnt_next != CNT_ZERO);
            r_tbr    <= (w_tx_cnt_next != CNT_FULL);
        end
    end

    // TX frame FSM; txd is registered and idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_st   <= ST_IDLE;
            r_tx_tcnt <= 4'd0;
            r_tx_bit  <= 3'd0;
            r_tx_sh   <= '0;
            r_tx_par  <= 1'b0;
            r_txd     <= 1'b1;
        end else if (w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 4'd1;
            case (r_tx_st)
                ST_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_sh   <= r_tx_mem[r_tx_rp];
                        r_tx_par  <= ^r_tx_mem[r_tx_rp];
                        r_tx_st   <= ST_START;
                        r_tx_tcnt <= 4'd0;
                        r_txd     <= 1'b0;
                    end else begin
                        r_txd <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_tx_tcnt == 4'd15) begin
                        r_tx_st  <= ST_DATA;
                        r_tx_bit <= 3'd0;
                        r_txd    <= r_tx_sh[0];
                    end
                end
                ST_DATA: begin
                    if (r_tx_tcnt == 4'd15) begin
                        if (r_tx_bit == LAST_BIT) begin
                            r_tx_st <= PAR_EN ? ST_PAR : ST_STOP;
                            r_txd   <= PAR_EN ? r_tx_par : 1'b1;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                            r_tx_sh  <= r_tx_sh >> 1;
                            r_txd    <= r_tx_sh[1];
                        end
                    end
                end
                ST_PAR: begin
                    if (r_tx_tcnt == 4'd15) begin
                        r_tx_st <= ST_STOP;
                        r_txd   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_tx_tcnt == 4'd15) begin
                        if (w_tx_pop) begin
                            r_tx_sh  <= r_tx_mem[r_tx_rp];
                            r_tx_par <= ^r_tx_mem[r_tx_rp];
                            r_tx_st  <= ST_START;
                            r_txd    <= 1'b0;
                        end else begin
                            r_tx_st <= ST_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx_st <= ST_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    // rxd two-flop synchroniser plus previous value for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_s1   <= rxd;
            r_rxd_s2   <= r_rxd_s1;
            r_rxd_prev <= r_rxd_s2;
        end
    end

    // RX frame FSM: start checked at tick 8, later bits every 16 ticks, back to idle at mid-stop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_st   <= ST_IDLE;
            r_rx_tcnt <= 4'd0;
            r_rx_bit  <= 3'd0;
            r_rx_sh   <= '0;
            r_rx_par  <= 1'b0;
        end else begin
            case (r_rx_st)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_rx_st   <= ST_START;
                        r_rx_tcnt <= 4'd0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd7) begin
                            r_rx_st   <= w_rxd ? ST_IDLE : ST_DATA;
                            r_rx_tcnt <= 4'd0;
                            r_rx_bit  <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd15) begin
                            r_rx_sh <= {w_rxd, r_rx_sh[FRAME_W-1:1]};
                            if (r_rx_bit == LAST_BIT) begin
                                r_rx_st <= PAR_EN ? ST_PAR : ST_STOP;
                            end else begin
                                r_rx_bit <= r_rx_bit + 3'd1;
                            end
                        end
                    end
                end
                ST_PAR: begin
                    if (w_tick) begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd15) begin
                            r_rx_par <= w_rxd;
                            r_rx_st  <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd15) begin
                            r_rx_st <= ST_IDLE;
                        end
                    end
                end
                default: r_rx_st <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a status read clears them unless a new error lands the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_perr <= w_perr_set | (r_perr & ~w_stat_rd);
            r_ferr <= w_ferr_set | (r_ferr & ~w_stat_rd);
            r_ovf  <= w_ovf_set  | (r_ovf  & ~w_stat_rd);
        end
    end

endmodule
